junction_phase_scheduler: RTL and testbench
===========================================

// Module: junction_phase_scheduler
// PURPOSE
//  Round-robin phase scheduler for an N-road junction. Gives one road green at a time.
//  Latches vehicle-sensor requests and enforces min/max green, yellow and all-red clearance.
//  All timing runs off an internal 1 s tick enable. Drives per-road 3-bit lamp codes.
// PARAMETERS
//  NUM_ROADS  4         number of approaches, >=2
//  TICK_DIV   50000000  clk cycles per tick (1 s at 50 MHz), >=2
//  MIN_GREEN  10        minimum green, in ticks, >=1
//  MAX_GREEN  30        max green while other roads wait, in ticks, >=MIN_GREEN
//  YELLOW_T   3         yellow duration, in ticks, >=1
//  ALLRED_T   1         all-red clearance, in ticks, >=1
// PORTS
//  clk      in   1            system clock
//  rst      in   1            asynchronous, active-low reset
//  sensor   in   NUM_ROADS    vehicle present on road i, level or pulse
//  lights   out  3*NUM_ROADS  road i lamp at [3i+2:3i]: 100 red, 010 yellow, 001 green
//  grant    out  NUM_ROADS    one-hot: road currently green or yellow; 0 in ALLRED
//  phase    out  2            00 ALLRED, 01 GREEN, 10 YELLOW
//  pending  out  NUM_ROADS    latched, unserved requests
//  tick     out  1            1-cycle tick strobe
// BEHAVIOUR
//  Reset (rst=0, acts immediately, not clocked):
//   - phase=ALLRED, cur=0, timer=0, tick counter=0, pending=0
//   - all lights=100, grant=0, tick=0
//  Tick generator:
//   - counter runs 0..TICK_DIV-1 and wraps
//   - tick=1 for the single cycle where counter==TICK_DIV-1
//  Outputs are decoded only from registered state (phase, cur, pending, counter).
//  No combinational path from sensor to any output.
//  Request latch:
//   - pending[i] is set on any clk edge where sensor[i]=1.
//   - Exception: no set while road i is green, and no set on the edge road i enters GREEN.
//   - pending[i] clears on the edge road i enters GREEN.
//   - For every road other than the one entering GREEN, set wins.
//  Timer:
//   - zeroed on every phase entry
//   - +1 on each tick; saturates at MAX_GREEN
//   - n = timer+1 is the completed-tick count at the evaluating tick
//  FSM (transitions only on cycles with tick=1):
//   - ALLRED: at n==ALLRED_T, pick the first i with pending[i]=1, searching cur+1, cur+2, ...
//     mod NUM_ROADS. If none, pick cur. Set cur=i, enter GREEN.
//   - GREEN: lights[cur]=001, others 100. Let other = |(pending & ~onehot(cur)).
//     Enter YELLOW if (n>=MIN_GREEN && other && !sensor[cur]) || (n>=MAX_GREEN && other).
//     Otherwise stay green indefinitely (rest-in-green).
//   - YELLOW: lights[cur]=010, others 100. At n==YELLOW_T enter ALLRED.
//  Safety invariants:
//   - never more than one road with lights other than 100
//   - grant is one-hot or zero
//   - illegal phase encoding is forced to ALLRED
//  Output timing: phase, lights and grant change on the same clk edge as the tick that
//  causes the transition.
// TESTING  (TICK_DIV=4, MIN_GREEN=2, MAX_GREEN=4, YELLOW_T=2, ALLRED_T=1, NUM_ROADS=4)
//  T1 reset, sensor=0 -> all 100 during reset. First tick after release: road0=001,
//     grant=0001, phase=01. Holds indefinitely.
//  T2 road0 green, 1-cycle pulse sensor[2] -> pending=0100.
//     At the 2nd green tick: road0=010 for 2 ticks (8 cycles), then all 100 for 1 tick.
//     Then road2=001, pending=0000.
//  T3 sensor[0] held 1, pulse sensor[1] -> road0 stays green until the 4th tick (MAX_GREEN).
//     Then yellow, all-red, road1 green.
//  T4 road2 green, sensor[1] and sensor[3] pulsed in the same cycle -> road3 served first,
//     then road1 (after its MIN_GREEN, yellow and all-red).
//  T5 rst=0 mid-YELLOW -> lights all 100 and pending=0 with no clock edge.
//     On release: T1 sequence.
//  T6 sensor[2]=1 only on the edge road2 enters GREEN -> pending[2] stays 0.
//     Self-check across all tests: no two roads non-red in any cycle.

Source files
------------

// File: rtl/junction_phase_scheduler.sv
// rtl/junction_phase_scheduler.sv - round-robin N-road junction phase scheduler
module junction_phase_scheduler #(
    parameter int NUM_ROADS = 4,
    parameter int TICK_DIV  = 50000000,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ROADS-1:0]   sensor,
    output logic [3*NUM_ROADS-1:0] lights,
    output logic [NUM_ROADS-1:0]   grant,
    output logic [1:0]             phase,
    output logic [NUM_ROADS-1:0]   pending,
    output logic                   tick
);
    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_t;

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int CUR_W = $clog2(NUM_ROADS);
    // Timer saturates at the longest interval any phase needs to count to.
    localparam int TMAX_A = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
    localparam int TMAX   = (TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T;
    localparam int TIM_W  = $clog2(TMAX + 1);

    logic [CNT_W-1:0]     cnt_q;
    phase_t               phase_q, phase_d;
    logic [CUR_W-1:0]     cur_q, cur_d, pick;
    logic [TIM_W-1:0]     timer_q, timer_d;
    logic [NUM_ROADS-1:0] pending_q, pending_d;
    logic [NUM_ROADS-1:0] cur_mask, pick_mask;
    logic [TIM_W:0]       n;
    logic                 other, enter_green;

    assign tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign cur_mask  = NUM_ROADS'(1) << cur_q;
    assign pick_mask = NUM_ROADS'(1) << pick;
    assign other     = |(pending_q & ~cur_mask);
    assign n         = {1'b0, timer_q} + (TIM_W+1)'(1);
    assign pending   = pending_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            phase_q   <= PH_ALLRED;
            cur_q     <= '0;
            timer_q   <= '0;
            pending_q <= '0;
        end else begin
            cnt_q     <= tick ? '0 : cnt_q + CNT_W'(1);
            phase_q   <= phase_d;
            cur_q     <= cur_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    // Round-robin search starting after the current road; falls back to cur.
    always_comb begin
        int idx;
        logic found;
        pick  = cur_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_ROADS; k++) begin
            idx = int'(cur_q) + k;
            if (idx >= NUM_ROADS) idx = idx - NUM_ROADS;
            if (!found && pending_q[CUR_W'(idx)]) begin
                pick  = CUR_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        phase_d     = phase_q;
        cur_d       = cur_q;
        timer_d     = timer_q;
        enter_green = 1'b0;
        if (tick) timer_d = (timer_q == TIM_W'(TMAX)) ? timer_q : timer_q + TIM_W'(1);
        case (phase_q)
            PH_ALLRED: begin
                if (tick && n == (TIM_W+1)'(ALLRED_T)) begin
                    phase_d     = PH_GREEN;
                    cur_d       = pick;
                    timer_d     = '0;
                    enter_green = 1'b1;
                end
            end
            PH_GREEN: begin
                if (tick && other &&
                    ((n >= (TIM_W+1)'(MIN_GREEN) && !sensor[cur_q]) ||
                     n >= (TIM_W+1)'(MAX_GREEN))) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                end
            end
            PH_YELLOW: begin
                if (tick && n == (TIM_W+1)'(YELLOW_T)) begin
                    phase_d = PH_ALLRED;
                    timer_d = '0;
                end
            end
            default: begin
                phase_d = PH_ALLRED;
                timer_d = '0;
            end
        endcase
    end

    // The road being green never latches its own request; entering green clears it.
    always_comb begin
        pending_d = pending_q | (sensor & ~((phase_q == PH_GREEN) ? cur_mask : '0));
        if (enter_green) pending_d = pending_d & ~pick_mask;
    end

    always_comb begin
        lights = {NUM_ROADS{3'b100}};
        grant  = '0;
        phase  = 2'b00;
        case (phase_q)
            PH_GREEN: begin
                lights[3*int'(cur_q) +: 3] = 3'b001;
                grant = cur_mask;
                phase = 2'b01;
            end
            PH_YELLOW: begin
                lights[3*int'(cur_q) +: 3] = 3'b010;
                grant = cur_mask;
                phase = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_junction_phase_scheduler.sv
// tb/tb_junction_phase_scheduler.sv - directed bench for junction_phase_scheduler
module tb_junction_phase_scheduler;
    localparam int NR = 4;
    localparam logic [11:0] L_ALLR = 12'h924;
    localparam logic [11:0] L_R0G  = 12'h921;
    localparam logic [11:0] L_R0Y  = 12'h922;
    localparam logic [11:0] L_R1G  = 12'h90C;
    localparam logic [11:0] L_R2G  = 12'h864;
    localparam logic [11:0] L_R3G  = 12'h324;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   sensor = '0;
    logic [3*NR-1:0] lights;
    logic [NR-1:0]   grant;
    logic [1:0]      phase;
    logic [NR-1:0]   pending;
    logic            tick;
    int              passed = 0;
    int              total = 0;
    bit              mon_en = 1'b0;

    junction_phase_scheduler #(
        .NUM_ROADS(NR), .TICK_DIV(4), .MIN_GREEN(2), .MAX_GREEN(4),
        .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .lights(lights),
        .grant(grant), .phase(phase), .pending(pending), .tick(tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && rst) begin
            int nr;
            nr = 0;
            for (int i = 0; i < NR; i++) if (lights[3*i +: 3] !== 3'b100) nr++;
            total++;
            if (nr > 1 || !$onehot0(grant))
                $display("FAIL safety lights=%h grant=%b", lights, grant);
            else passed++;
        end
    end

    task automatic wait_tick_high();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            $display("FAIL tick_timeout got no tick in 20 cycles, required one");
        end
    endtask

    task automatic tick_edge();
        wait_tick_high();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NR-1:0] v);
        @(negedge clk);
        sensor = v;
        @(negedge clk);
        sensor = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (lights !== L_ALLR) $display("FAIL t1_rst_lights got %h exp %h", lights, L_ALLR); else passed++;
        total++; if (grant !== 4'b0000) $display("FAIL t1_rst_grant got %b exp 0000", grant); else passed++;
        total++; if (phase !== 2'b00) $display("FAIL t1_rst_phase got %b exp 00", phase); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL t1_rst_pending got %b exp 0000", pending); else passed++;
        total++; if (tick !== 1'b0) $display("FAIL t1_rst_tick got %b exp 0", tick); else passed++;
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        tick_edge();
        total++; if (lights !== L_R0G) $display("FAIL t1_green_lights got %h exp %h", lights, L_R0G); else passed++;
        total++; if (grant !== 4'b0001) $display("FAIL t1_green_grant got %b exp 0001", grant); else passed++;
        total++; if (phase !== 2'b01) $display("FAIL t1_green_phase got %b exp 01", phase); else passed++;
        total++; if (tick !== 1'b0) $display("FAIL t1_tick_one_cycle got %b exp 0", tick); else passed++;
        for (int t = 0; t < 6; t++) begin
            tick_edge();
            total++; if (lights !== L_R0G) $display("FAIL t1_hold%0d got %h exp %h", t, lights, L_R0G); else passed++;
        end
    endtask

    task automatic test_min_green();
        do_reset();
        tick_edge();
        pulse(4'b0100);
        total++; if (pending !== 4'b0100) $display("FAIL t2_pending got %b exp 0100", pending); else passed++;
        tick_edge();
        total++; if (lights !== L_R0G) $display("FAIL t2_tick1 got %h exp %h", lights, L_R0G); else passed++;
        tick_edge();
        total++; if (lights !== L_R0Y) $display("FAIL t2_yellow got %h exp %h", lights, L_R0Y); else passed++;
        total++; if (phase !== 2'b10) $display("FAIL t2_yellow_phase got %b exp 10", phase); else passed++;
        tick_edge();
        total++; if (lights !== L_R0Y) $display("FAIL t2_yellow2 got %h exp %h", lights, L_R0Y); else passed++;
        tick_edge();
        total++; if (lights !== L_ALLR) $display("FAIL t2_allred got %h exp %h", lights, L_ALLR); else passed++;
        total++; if (grant !== 4'b0000) $display("FAIL t2_allred_grant got %b exp 0000", grant); else passed++;
        tick_edge();
        total++; if (lights !== L_R2G) $display("FAIL t2_r2_green got %h exp %h", lights, L_R2G); else passed++;
        total++; if (grant !== 4'b0100) $display("FAIL t2_r2_grant got %b exp 0100", grant); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL t2_r2_pending got %b exp 0000", pending); else passed++;
    endtask

    task automatic test_max_green();
        do_reset();
        tick_edge();
        @(negedge clk);
        sensor = 4'b0011;
        @(negedge clk);
        sensor = 4'b0001;
        total++; if (pending !== 4'b0010) $display("FAIL t3_pending got %b exp 0010", pending); else passed++;
        for (int t = 1; t <= 3; t++) begin
            tick_edge();
            total++; if (phase !== 2'b01) $display("FAIL t3_hold%0d got %b exp 01", t, phase); else passed++;
        end
        tick_edge();
        sensor = '0;
        total++; if (lights !== L_R0Y) $display("FAIL t3_yellow got %h exp %h", lights, L_R0Y); else passed++;
        tick_edge();
        tick_edge();
        total++; if (lights !== L_ALLR) $display("FAIL t3_allred got %h exp %h", lights, L_ALLR); else passed++;
        tick_edge();
        total++; if (lights !== L_R1G) $display("FAIL t3_r1_green got %h exp %h", lights, L_R1G); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL t3_pending_after got %b exp 0000", pending); else passed++;
    endtask

    task automatic test_round_robin();
        pulse(4'b0100);
        repeat (5) tick_edge();
        total++; if (lights !== L_R2G) $display("FAIL t4_r2_green got %h exp %h", lights, L_R2G); else passed++;
        pulse(4'b1010);
        total++; if (pending !== 4'b1010) $display("FAIL t4_pending got %b exp 1010", pending); else passed++;
        repeat (5) tick_edge();
        total++; if (lights !== L_R3G) $display("FAIL t4_r3_first got %h exp %h", lights, L_R3G); else passed++;
        total++; if (pending !== 4'b0010) $display("FAIL t4_pending_r1 got %b exp 0010", pending); else passed++;
        tick_edge();
        total++; if (phase !== 2'b01) $display("FAIL t4_r3_min got %b exp 01", phase); else passed++;
        repeat (4) tick_edge();
        total++; if (lights !== L_R1G) $display("FAIL t4_r1_next got %h exp %h", lights, L_R1G); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL t4_pending_end got %b exp 0000", pending); else passed++;
    endtask

    task automatic test_reset_mid_yellow();
        pulse(4'b0001);
        tick_edge();
        tick_edge();
        total++; if (phase !== 2'b10) $display("FAIL t5_in_yellow got %b exp 10", phase); else passed++;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (lights !== L_ALLR) $display("FAIL t5_async_lights got %h exp %h", lights, L_ALLR); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL t5_async_pending got %b exp 0000", pending); else passed++;
        total++; if (grant !== 4'b0000) $display("FAIL t5_async_grant got %b exp 0000", grant); else passed++;
        @(negedge clk);
        rst = 1'b1;
        tick_edge();
        total++; if (lights !== L_R0G) $display("FAIL t5_restart got %h exp %h", lights, L_R0G); else passed++;
    endtask

    task automatic test_entry_edge_sensor();
        pulse(4'b0100);
        repeat (4) tick_edge();
        total++; if (phase !== 2'b00) $display("FAIL t6_allred got %b exp 00", phase); else passed++;
        wait_tick_high();
        sensor = 4'b0100;
        @(posedge clk);
        #1 sensor = '0;
        total++; if (lights !== L_R2G) $display("FAIL t6_r2_green got %h exp %h", lights, L_R2G); else passed++;
        total++; if (pending !== 4'b0000) $display("FAIL t6_pending got %b exp 0000", pending); else passed++;
    endtask

    initial begin
        test_reset();
        test_min_green();
        test_max_green();
        test_round_robin();
        test_reset_mid_yellow();
        test_entry_edge_sensor();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
